// File: rtl/sim_finish_ctrl.sv
// Design-side simulation finish controller: arbitrates finish requests, waits for a quiet
// drain window, then raises a sticky finish level. Optional watchdog: SIM_WATCHDOG_EN.
module sim_finish_ctrl #(
   parameter int unsigned NSRC            = 4,
   parameter int unsigned CODE_W          = 8,
   parameter int unsigned DRAIN_CYCLES    = 16,
   parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NSRC-1:0]          req_valid,
   input  logic [NSRC*CODE_W-1:0]   req_code,
   output logic [NSRC-1:0]          req_ready,
   input  logic                     quiesce_in,
   output logic [31:0]              cycle_count,
   output logic [1:0]               state,
   output logic                     finish,
   output logic [CODE_W-1:0]        finish_code,
   output logic [3:0]               finish_src,
   output logic                     timeout
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e              state_q;
   logic [31:0]         drain_cnt_q;
   logic [NSRC-1:0]     win_oh;
   logic [CODE_W-1:0]   win_code;
   logic [3:0]          win_src;

   // Scan from the top so the lowest-index requester is the last (winning) assignment.
   always_comb begin
      win_oh   = '0;
      win_code = '0;
      win_src  = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_code  = req_code[i*CODE_W +: CODE_W];
            win_src   = 4'(i);
         end
      end
   end

   assign state = state_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         req_ready   <= '0;
         cycle_count <= '0;
         finish      <= 1'b0;
         finish_code <= '0;
         finish_src  <= '0;
         drain_cnt_q <= '0;
`ifdef SIM_WATCHDOG_EN
         timeout     <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         unique case (state_q)
            StIdle: state_q <= StRun;
            StRun, StDrain: begin
`ifdef SIM_WATCHDOG_EN
               // Watchdog pre-empts any acceptance or drain progress on the same edge.
               if (cycle_count == WATCHDOG_CYCLES) begin
                  state_q     <= StDone;
                  finish      <= 1'b1;
                  timeout     <= 1'b1;
                  finish_code <= '1;
                  finish_src  <= 4'hF;
               end else
`endif
               begin
                  if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
                  if (state_q == StRun) begin
                     if (|req_valid) begin
                        req_ready   <= win_oh;
                        finish_code <= win_code;
                        finish_src  <= win_src;
                        drain_cnt_q <= DRAIN_CYCLES;
                        state_q     <= StDrain;
                     end
                  end else if (!quiesce_in) begin
                     drain_cnt_q <= DRAIN_CYCLES;
                  end else if (drain_cnt_q == '0) begin
                     state_q <= StDone;
                     finish  <= 1'b1;
                  end else begin
                     drain_cnt_q <= drain_cnt_q - 32'd1;
                  end
               end
            end
            StDone: begin
            end
         endcase
      end
   end

`ifndef SIM_WATCHDOG_EN
   // No watchdog in this build; the limit parameter has no effect.
   assign timeout = 1'b0 && (WATCHDOG_CYCLES != 0);
`endif

endmodule
